// File: rtl/grf_dump.sv
// GRF dump engine: walks the register file through one read port and streams
// (address, value) beats over valid/ready, bypassing/snooping GRF writes.
module grf_dump #(
   parameter int NREG      = 32,
   parameter int AW        = 5,
   parameter int DW        = 32,
   parameter bit SKIP_ZERO = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] RA,
   input  logic [DW-1:0] busA,
   input  logic          RegWrite,
   input  logic [AW-1:0] RW,
   input  logic [DW-1:0] busW,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] FIRST_IDX = SKIP_ZERO ? AW'(1) : AW'(0);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW-1:0] ra_q, ra_d;
   logic          out_valid_q, out_valid_d;
   logic [AW-1:0] out_addr_q, out_addr_d;
   logic [DW-1:0] out_data_q, out_data_d;

   logic          fetch_hit;
   logic          snoop_hit;

   // The GRF returns the pre-write value during a write cycle, so a write
   // landing on the fetched register must be forwarded from busW.
   assign fetch_hit = RegWrite && (RW == idx_q) && (idx_q != '0);
   assign snoop_hit = RegWrite && (RW == out_addr_q) && (RW != '0);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_FETCH;
               idx_d   = FIRST_IDX;
            end
         end
         ST_FETCH: begin
            out_addr_d  = idx_q;
            out_data_d  = fetch_hit ? busW : busA;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (snoop_hit) begin
               out_data_d = busW;
            end
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides everything else, including a same-edge handshake.
      if (abort && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
         idx_d       = '0;
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      ra_d   = (state_d == ST_FETCH) ? idx_d : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ra_q        <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ra_q        <= ra_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign RA        = ra_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_grf_dump.sv
// Scoreboard bench for grf_dump: a behavioural GRF feeds two instances
// (SKIP_ZERO=1 and SKIP_ZERO=0); monitors pop expected beats on each handshake.
module tb_grf_dump;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, abort, RegWrite, out_ready, grf_clr;
   logic [AW-1:0] RW;
   logic [DW-1:0] busW;
   logic          busy, done, out_valid;
   logic [AW-1:0] RA, out_addr;
   logic [DW-1:0] busA, out_data;
   logic          start0, out_ready0, busy0, done0, out_valid0;
   logic [AW-1:0] RA0, out_addr0;
   logic [DW-1:0] busA0, out_data0;

   logic [DW-1:0] grf [NREG];
   assign busA  = grf[RA];
   assign busA0 = grf[RA0];

   always @(posedge clk) begin
      if (grf_clr) begin
         for (int i = 0; i < NREG; i++) grf[i] <= '0;
      end else if (RegWrite && RW != '0) begin
         grf[RW] <= busW;
      end
   end

   grf_dump #(.NREG(NREG), .AW(AW), .DW(DW), .SKIP_ZERO(1'b1)) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(busy), .done(done), .RA(RA), .busA(busA),
      .RegWrite(RegWrite), .RW(RW), .busW(busW),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data)
   );

   grf_dump #(.NREG(NREG), .AW(AW), .DW(DW), .SKIP_ZERO(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start0), .abort(abort),
      .busy(busy0), .done(done0), .RA(RA0), .busA(busA0),
      .RegWrite(RegWrite), .RW(RW), .busW(busW),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .out_addr(out_addr0), .out_data(out_data0)
   );

   int pass_cnt   = 0;
   int total_cnt  = 0;
   int beats      = 0;
   int beats0     = 0;
   int done_seen  = 0;
   int done_seen0 = 0;
   beat_t exp_q[$];
   beat_t exp0_q[$];
   beat_t mon_e, mon0_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, required %h", name, act, exp);
   endtask

   task automatic fail_now(input string name, input string what);
      total_cnt++;
      $display("FAIL %s: %s", name, what);
   endtask

   always @(negedge clk) begin
      if (done) done_seen++;
      if (out_valid && out_ready) begin
         beats++;
         $display("beat skip1 addr=%0d data=%h", out_addr, out_data);
         if (exp_q.size() == 0) begin
            fail_now("unexpected_beat", $sformatf("got addr %0d, required no beat", out_addr));
         end else begin
            mon_e = exp_q.pop_front();
            check("beat", 64'({out_addr, out_data}), 64'({mon_e.a, mon_e.d}));
         end
      end
   end

   always @(negedge clk) begin
      if (done0) done_seen0++;
      if (out_valid0 && out_ready0) begin
         beats0++;
         $display("beat skip0 addr=%0d data=%h", out_addr0, out_data0);
         if (exp0_q.size() == 0) begin
            fail_now("unexpected_beat0", $sformatf("got addr %0d, required no beat", out_addr0));
         end else begin
            mon0_e = exp0_q.pop_front();
            check("beat0", 64'({out_addr0, out_data0}), 64'({mon0_e.a, mon0_e.d}));
         end
      end
   end

   task automatic push_range(input int lo, input int hi, input bit to0);
      for (int a = lo; a <= hi; a++) begin
         beat_t b;
         b.a = AW'(a);
         b.d = grf[a];
         if (to0) exp0_q.push_back(b);
         else     exp_q.push_back(b);
      end
   endtask

   task automatic set_exp(input int addr, input logic [DW-1:0] data);
      foreach (exp_q[i]) if (int'(exp_q[i].a) == addr) exp_q[i].d = data;
   endtask

   task automatic wr(input int addr, input logic [DW-1:0] data);
      @(posedge clk); #1;
      RegWrite = 1'b1; RW = AW'(addr); busW = data;
      @(posedge clk); #1;
      RegWrite = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic wait_addr(input int a, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (out_valid && int'(out_addr) == a) begin
            ok = 1'b1;
            return;
         end
      end
      fail_now("wait_addr_timeout", $sformatf("addr %0d never presented", a));
   endtask

   // Runs one dump to completion; optional stall on stall_addr, snoop writes
   // at addr5, same-cycle write at FETCH of addr7, and a stray start at addr10.
   task automatic run_dump(input int stall_addr, input bit snoop5, input bit byp7, input bit restart);
      int n = exp_q.size();
      int b0 = beats;
      int d0 = done_seen;
      bit fin = 1'b0;
      int stalls = 0;
      bit released = 1'b0;
      int sstep = 0;
      bit byp_done = 1'b0;
      bit restarted = 1'b0;
      out_ready = 1'b1;
      pulse_start();
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         RegWrite = 1'b0;
         start = 1'b0;
         if (exp_q.size() == 0) begin
            fin = 1'b1;
            break;
         end
         if (released) begin
            check("stall_accept", 64'(out_valid), 64'(0));
            released = 1'b0;
         end
         if (out_valid && int'(out_addr) == stall_addr && stalls < 5) begin
            check("stall_hold", 64'({out_valid, out_addr, out_data}), 64'({1'b1, 5'd3, 32'h0000_3333}));
            out_ready = 1'b0;
            stalls++;
         end else if (snoop5 && out_valid && out_addr == 5'd5 && sstep < 3) begin
            if (sstep == 0) begin
               RegWrite = 1'b1; RW = 5'd5; busW = 32'hDEAD; out_ready = 1'b0;
            end else if (sstep == 1) begin
               check("snoop_write", 64'(out_data), 64'(32'hDEAD));
               RegWrite = 1'b1; RW = 5'd0; busW = 32'd1; out_ready = 1'b0;
            end else begin
               check("snoop_zero", 64'(out_data), 64'(32'hDEAD));
               out_ready = 1'b1;
            end
            sstep++;
         end else begin
            if (out_valid && int'(out_addr) == stall_addr && !out_ready) released = 1'b1;
            out_ready = 1'b1;
            if (byp7 && !byp_done && !out_valid && RA == 5'd7) begin
               RegWrite = 1'b1; RW = 5'd7; busW = 32'd99; byp_done = 1'b1;
            end
            if (restart && !restarted && out_valid && out_addr == 5'd10) begin
               start = 1'b1; restarted = 1'b1;
            end
         end
      end
      if (!fin) begin
         fail_now("dump_timeout", $sformatf("%0d beats still expected", exp_q.size()));
         return;
      end
      check("done_pulse", 64'({done, busy}), 64'(2'b11));
      @(posedge clk); #1;
      check("done_end", 64'({done, busy}), 64'(0));
      check("done_count", 64'(done_seen - d0), 64'(1));
      check("beat_count", 64'(beats - b0), 64'(n));
   endtask

   initial begin
      bit ok;
      int d0;
      reset = 1'b0; start = 1'b0; abort = 1'b0; RegWrite = 1'b0; RW = '0; busW = '0;
      out_ready = 1'b0; start0 = 1'b0; out_ready0 = 1'b1; grf_clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 64'({busy, done, out_valid, RA, out_addr, out_data}), 64'(0));
      check("reset_state0", 64'({busy0, done0, out_valid0, RA0, out_addr0, out_data0}), 64'(0));
      grf_clr = 1'b0;
      reset = 1'b1;

      // Basic full dump.
      wr(1, 32'd1234);
      wr(12, 32'd77);
      push_range(1, 31, 1'b0);
      run_dump(-1, 1'b0, 1'b0, 1'b0);

      // Back-pressure at addr3, snoop at addr5, fetch bypass at addr7.
      wr(3, 32'h0000_3333);
      wr(5, 32'h0000_5555);
      wr(7, 32'h0000_7777);
      push_range(1, 31, 1'b0);
      set_exp(5, 32'hDEAD);
      set_exp(7, 32'd99);
      run_dump(3, 1'b1, 1'b1, 1'b0);

      // Stray start mid-dump must not restart or add beats.
      push_range(1, 31, 1'b0);
      run_dump(-1, 1'b0, 1'b0, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("no_restart_busy", 64'(busy), 64'(0));

      // Asynchronous reset while holding addr10.
      wr(10, 32'd555);
      d0 = done_seen;
      push_range(1, 10, 1'b0);
      out_ready = 1'b1;
      pulse_start();
      wait_addr(10, ok);
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      check("async_reset_out", 64'({busy, done, out_valid, RA, out_addr, out_data}), 64'(0));
      check("async_reset_queue", 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("no_resume", 64'({busy, out_valid}), 64'(0));
      check("reset_no_done", 64'(done_seen - d0), 64'(0));

      // Abort while holding addr4, racing the handshake.
      push_range(1, 4, 1'b0);
      pulse_start();
      wait_addr(4, ok);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_idle", 64'({busy, out_valid, done}), 64'(0));
      check("abort_queue", 64'(exp_q.size()), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_seen - d0), 64'(0));

      // start and abort together in IDLE: abort wins.
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle", 64'(busy), 64'(0));

      // Full dump after abort.
      push_range(1, 31, 1'b0);
      run_dump(-1, 1'b0, 1'b0, 1'b0);

      // SKIP_ZERO=0 instance: 32 beats starting at $0.
      d0 = done_seen0;
      push_range(0, 31, 1'b1);
      check("skip0_first_data", 64'(exp0_q[0].d), 64'(0));
      @(posedge clk); #1; start0 = 1'b1;
      @(posedge clk); #1; start0 = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (exp0_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("skip0_timeout", $sformatf("%0d beats still expected", exp0_q.size()));
      check("skip0_done", 64'({done0, busy0}), 64'(2'b11));
      @(posedge clk); #1;
      check("skip0_idle", 64'({done0, busy0}), 64'(0));
      check("skip0_beats", 64'(beats0), 64'(32));
      check("skip0_done_count", 64'(done_seen0 - d0), 64'(1));

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
